// File: rtl/unary_op_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// unary_op_arbiter: round-robin arbiter sharing one registered unary-op unit.
// Option macro: UNARY_OP_ARB_ILLEGAL_TRAP_EN (op 7 yields 0, sets sticky out_err)
// Revision: 1.0
// ----------------------------------------------------------------------------
module unary_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         in_valid,
  output logic [NUM_REQ-1:0]         in_ready,
  input  logic [3*NUM_REQ-1:0]       in_op,
  input  logic [WIDTH*NUM_REQ-1:0]   in_operand,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [$clog2(NUM_REQ)-1:0] out_req_id,
  output logic                       out_err
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_NEG  = 3'd1;
  localparam logic [2:0] OP_LNOT = 3'd2;
  localparam logic [2:0] OP_BNOT = 3'd3;
  localparam logic [2:0] OP_RAND = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [ID_W-1:0]  out_req_id_q, out_req_id_d;

  logic             slot_free;
  logic             grant_any;
  logic             take;
  logic             hi_any;
  logic [ID_W-1:0]  hi_idx, lo_idx, grant_idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_operand;
  logic [WIDTH-1:0] op_result;

  assign slot_free = !out_valid_q || out_ready;
  assign grant_any = |in_valid;
  assign take      = slot_free && grant_any;

  // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) > last_grant_q) begin
          hi_idx = ID_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign grant_idx = hi_any ? hi_idx : lo_idx;

  always_comb begin
    in_ready = '0;
    if (take && !rst) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_op      = '0;
    sel_operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_op      = in_op[3*i +: 3];
        sel_operand = in_operand[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    case (sel_op)
      OP_PASS: op_result = sel_operand;
      OP_NEG:  op_result = -sel_operand;
      OP_LNOT: op_result = WIDTH'(!sel_operand[0]);
      OP_BNOT: op_result = ~sel_operand;
      OP_RAND: op_result = WIDTH'(&sel_operand);
      OP_INC:  op_result = sel_operand + WIDTH'(1);
      OP_DEC:  op_result = sel_operand - WIDTH'(1);
      default: begin
`ifdef UNARY_OP_ARB_ILLEGAL_TRAP_EN
        op_result = '0;
`else
        op_result = sel_operand;
`endif
      end
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_req_id_d = out_req_id_q;
    if (take) begin
      last_grant_d = grant_idx;
      out_valid_d  = 1'b1;
      out_result_d = op_result;
      out_req_id_d = grant_idx;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_req_id_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_req_id_q <= out_req_id_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_req_id = out_req_id_q;

`ifdef UNARY_OP_ARB_ILLEGAL_TRAP_EN
  logic err_q, err_d;

  assign err_d = err_q || (take && (sel_op == OP_ILL));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/unary_op_arbiter.md
# unary_op_arbiter

Round-robin arbiter and sequencer that shares one registered unary-operation unit (pass, negate, logical-not, bitwise-not, reduction-AND, increment, decrement) among NUM_REQ requesters. Each requester presents an opcode and operand with a valid/ready handshake. The block grants one requester per cycle, computes the result, and holds it in a single output register tagged with the requester index until the consumer accepts it. It sits between the operator-expression test clients and the shared unary datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits (2..32)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_REQ  per-requester request valid
- in_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- in_op  input  3*NUM_REQ  opcode, requester i at [3i+2:3i]
- in_operand  input  WIDTH*NUM_REQ  operand, requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  computed result
- out_req_id  output  $clog2(NUM_REQ)  index of the requester that produced out_result
- out_err  output  1  sticky illegal-opcode flag (only with trap enabled, else tied 0)

## Operation
- Opcodes:
  - 0 PASS: operand.
  - 1 NEG: two's complement negate mod 2^WIDTH.
  - 2 LNOT: {WIDTH-1 zeros, !operand[0]}.
  - 3 BNOT: ~operand.
  - 4 RAND: {zeros, &operand}.
  - 5 INC: operand+1 mod 2^WIDTH.
  - 6 DEC: operand-1 mod 2^WIDTH.
  - 7: illegal (see Configuration).
- Slot free when out_valid==0 or out_ready==1 (same-cycle drain and refill allowed).
- Arbitration runs only when the slot is free. Among asserted in_valid, grant the first index strictly after last_grant, in circular order. Assert in_ready for that index only; the transfer happens this cycle.
- On grant: result, id and out_valid=1 are registered; last_grant <= granted index.
- Slot free and no in_valid: if out_ready then out_valid<=0; last_grant unchanged.
- Slot not free: in_ready all zero; out_* held stable.
- Requesters must hold in_valid/in_op/in_operand until accepted. The arbiter does not depend on this.
- State: last_grant, out register, sticky err.

## Timing
- Reset: out_valid=0, out_result=0, out_req_id=0, out_err=0, in_ready=0 during rst, last_grant=NUM_REQ-1 (requester 0 wins first).
- in_ready is combinational from in_valid, out_valid, out_ready, last_grant. There is no combinational path from in_op/in_operand to outputs.
- Latency: grant at cycle N, out_valid/result visible cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0... Any waiting requester is granted within NUM_REQ grants.
- Reset asserted mid-transfer: the pending result is discarded and no in_ready is asserted in that cycle.

## Configuration
- UNARY_OP_ARB_ILLEGAL_TRAP_EN defined:
  - op 7 is still granted and completes normally.
  - Its result is 0.
  - out_err is set the cycle the result registers and stays set until rst.
- Not defined:
  - op 7 behaves as PASS.
  - out_err is constant 0.

## Test plan
- Reset, then requester 0 only with op=1, operand=8'h05 -> in_ready[0]=1, next cycle out_valid=1, out_result=8'hFB, out_req_id=0.
- All 4 requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, one result per cycle.
- Ops 2,3,4 on operand 8'hFF -> results 8'h00, 8'h00, 8'h01; INC on 8'hFF -> 8'h00; DEC on 8'h00 -> 8'hFF.
- out_ready=0 for 3 cycles with result pending and requesters valid -> in_ready=0, out_result/out_req_id stable. out_ready=1 -> same-cycle drain and next grant.
- op=7, operand=8'h3C: with trap -> result 8'h00, out_err=1 sticky until rst; without trap -> result 8'h3C, out_err=0.
- rst asserted while out_valid=1 and requester 2 valid -> next cycle out_valid=0, out_err=0. After release, requester 0 has priority if valid.
